// File: rtl/axi_rd_issue_ctrl_if.sv
// AR/R handshake wires that the read-issue controller observes or gates.
// Payload fields bypass this block and are not part of the interface.
interface axi_rd_issue_ctrl_if;
  logic s_axi_arvalid;
  logic s_axi_arready;
  logic m_axi_arvalid;
  logic m_axi_arready;
  logic m_axi_rvalid;
  logic m_axi_rready;
  logic m_axi_rlast;

  // Controller side: gates the AR handshake and watches R.
  modport slave (
    input  s_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rvalid,
    input  m_axi_rready,
    input  m_axi_rlast,
    output s_axi_arready,
    output m_axi_arvalid
  );

  // Environment side: upstream master, downstream slave and R observer.
  modport master (
    output s_axi_arvalid,
    output m_axi_arready,
    output m_axi_rvalid,
    output m_axi_rready,
    output m_axi_rlast,
    input  s_axi_arready,
    input  m_axi_arvalid
  );
endinterface

// File: rtl/axi_rd_issue_ctrl.sv
// AXI read-issue controller: limits outstanding read bursts and provides a pause/drain sequence.
// Optional AR stall statistics are enabled with the macro AXI_RD_ISSUE_CTRL_STATS_EN.
module axi_rd_issue_ctrl #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_rd_issue_ctrl_if.slave   bus,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] cfg_limit,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 status_idle,
  output logic                 status_limit,
  output logic                 err_underflow,
  output logic [31:0]          stall_cycles,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] count, count_next;
  logic [CNT_WIDTH-1:0] eff_limit;
  logic                 under_limit;
  logic                 allow;
  logic                 issue;
  logic                 done;
  logic                 underflow_hit;
  logic                 err_q;

  assign eff_limit   = (cfg_limit > MAX_CNT) ? MAX_CNT : cfg_limit;
  assign under_limit = (count < eff_limit);
  // enable is folded in so a pause blocks AR in the very cycle it is requested.
  assign allow       = (state == RUN) && enable && under_limit;

  // Handshake: a transfer happens on a cycle where valid && ready are both high.
  // Valid never depends on ready; this block only masks the existing valid and
  // ready with allow, so it never raises either one on its own.
  assign bus.m_axi_arvalid = bus.s_axi_arvalid & allow;
  assign bus.s_axi_arready = bus.m_axi_arready & allow;

  assign issue = bus.m_axi_arvalid & bus.m_axi_arready;
  assign done  = bus.m_axi_rvalid & bus.m_axi_rready & bus.m_axi_rlast;

  always_comb begin
    count_next    = count;
    underflow_hit = 1'b0;
    if (issue && !done) begin
      count_next = count + CNT_WIDTH'(1);
    end else if (done && !issue) begin
      if (count == '0) begin
        underflow_hit = 1'b1;
      end else begin
        count_next = count - CNT_WIDTH'(1);
      end
    end
  end

  // Transitions look at the post-update count so a drain ends on the last completion edge.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (!enable) state_next = (count_next == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable)                  state_next = RUN;
        else if (count_next == '0)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (underflow_hit) err_q <= 1'b1;
    end
  end

  assign outstanding   = count;
  assign status_idle   = (state == IDLE);
  assign status_limit  = (state == RUN) && !under_limit;
  assign err_underflow = err_q;
  assign state_dbg     = state;

`ifdef AXI_RD_ISSUE_CTRL_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.s_axi_arvalid && !allow && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_axi_rd_issue_ctrl.sv
// Directed bench for axi_rd_issue_ctrl: a burst-count model checked every cycle plus
// hand-computed expectations for limit, drain, clamp, underflow and stall scenarios.
module tb_axi_rd_issue_ctrl;
  localparam int MAXO = 16;
  localparam int CW   = $clog2(MAXO + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rd_issue_ctrl_if bus ();

  logic          enable;
  logic [CW-1:0] cfg_limit;
  logic [CW-1:0] outstanding;
  logic          status_idle;
  logic          status_limit;
  logic          err_underflow;
  logic [31:0]   stall_cycles;
  logic [1:0]    state_dbg;

  axi_rd_issue_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .enable        (enable),
    .cfg_limit     (cfg_limit),
    .outstanding   (outstanding),
    .status_idle   (status_idle),
    .status_limit  (status_limit),
    .err_underflow (err_underflow),
    .stall_cycles  (stall_cycles),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 paused/idle, 1 issuing, 2 waiting for in-flight bursts to return
  int          m_mode;
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_stall;

  function automatic int lim_of(input int cfg);
    return (cfg > MAXO) ? MAXO : cfg;
  endfunction

  function automatic bit may_issue();
    return (m_mode == 1) && enable && (m_cnt < lim_of(int'(cfg_limit)));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
      m_stall = 32'd0;
    end else begin
      bit ok, iss, dn;
      ok  = may_issue();
      iss = ok && bus.s_axi_arvalid && bus.m_axi_arready;
      dn  = bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast;
      if (bus.s_axi_arvalid && !ok && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (iss && !dn) m_cnt = m_cnt + 1;
      else if (dn && !iss) begin
        if (m_cnt == 0) m_err = 1'b1;
        else m_cnt = m_cnt - 1;
      end
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: if (!enable) m_mode = (m_cnt == 0) ? 0 : 2;
        default: if (enable) m_mode = 1; else if (m_cnt == 0) m_mode = 0;
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      bit ok;
      ok = may_issue();
      chk("m_arvalid",   bus.m_axi_arvalid, bus.s_axi_arvalid & ok);
      chk("s_arready",   bus.s_axi_arready, bus.m_axi_arready & ok);
      chk("outstanding", outstanding, m_cnt);
      chk("status_idle", status_idle, m_mode == 0);
      chk("status_limit", status_limit, (m_mode == 1) && !(m_cnt < lim_of(int'(cfg_limit))));
      chk("err_underflow", err_underflow, m_err);
`ifdef AXI_RD_ISSUE_CTRL_STATS_EN
      chk("stall_cycles", stall_cycles, m_stall);
`else
      chk("stall_cycles", stall_cycles, 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_r(input bit v);
    bus.m_axi_rvalid = v;
    bus.m_axi_rready = v;
    bus.m_axi_rlast  = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    cfg_limit = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.m_axi_arready = 1'b0;
    set_r(1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", status_idle, 1);
    chk("rst_err", err_underflow, 0);
    chk("rst_stall", stall_cycles, 0);

    // Limit of 4: four back-to-back issues, then blocked.
    cfg_limit = CW'(4);
    enable = 1'b1;
    tick();
    bus.s_axi_arvalid = 1'b1;
    bus.m_axi_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("lim4_accept", bus.s_axi_arready, 1);
      tick();
    end
    settle();
    chk("lim4_count", outstanding, 4);
    chk("lim4_block", bus.s_axi_arready, 0);
    chk("lim4_status", status_limit, 1);

    // At the limit a completion frees a slot; then issue+done together hold the count.
    set_r(1'b1);
    settle();
    chk("full_no_accept", bus.s_axi_arready, 0);
    tick();
    chk("after_done", outstanding, 3);
    settle();
    chk("both_accept", bus.s_axi_arready, 1);
    tick();
    chk("both_hold", outstanding, 3);
    set_r(1'b0);
    tick();
    chk("refill", outstanding, 4);
    settle();
    chk("refill_block", bus.s_axi_arready, 0);
    tick();
    chk("refill_hold", outstanding, 4);

    // Pause at count 3: same-cycle block, drain to idle.
    bus.s_axi_arvalid = 1'b0;
    set_r(1'b1);
    tick();
    set_r(1'b0);
    enable = 1'b0;
    bus.s_axi_arvalid = 1'b1;
    settle();
    chk("pause_s_ready", bus.s_axi_arready, 0);
    chk("pause_m_valid", bus.m_axi_arvalid, 0);
    tick();
    chk("drain_busy", status_idle, 0);
    chk("drain_count", outstanding, 3);
    bus.s_axi_arvalid = 1'b0;
    set_r(1'b1);
    repeat (3) tick();
    set_r(1'b0);
    chk("drain_empty", outstanding, 0);
    chk("drain_idle", status_idle, 1);

    // Limit above MAX_OUTSTANDING is clamped; limit 0 blocks.
    cfg_limit = CW'(20);
    enable = 1'b1;
    tick();
    bus.s_axi_arvalid = 1'b1;
    repeat (18) tick();
    chk("clamp_count", outstanding, 16);
    chk("clamp_status", status_limit, 1);
    chk("clamp_block", bus.s_axi_arready, 0);
    cfg_limit = CW'(0);
    set_r(1'b1);
    tick();
    set_r(1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("zero_block", bus.s_axi_arready, 0);
      tick();
    end
    chk("zero_count", outstanding, 15);
    cfg_limit = CW'(16);
    settle();
    chk("reraise_accept", bus.s_axi_arready, 1);
    tick();
    chk("reraise_count", outstanding, 16);

    // Drain everything, then an extra completion is an underflow.
    bus.s_axi_arvalid = 1'b0;
    enable = 1'b0;
    set_r(1'b1);
    repeat (16) tick();
    chk("empty_count", outstanding, 0);
    chk("empty_idle", status_idle, 1);
    chk("no_err_yet", err_underflow, 0);
    tick();
    set_r(1'b0);
    chk("uf_err", err_underflow, 1);
    chk("uf_count", outstanding, 0);
    tick();
    tick();
    chk("uf_sticky", err_underflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("uf_clear", err_underflow, 0);
    chk("uf_clear_count", outstanding, 0);

    // Ten blocked AR cycles while idle.
    bus.s_axi_arvalid = 1'b1;
    repeat (10) tick();
    bus.s_axi_arvalid = 1'b0;
`ifdef AXI_RD_ISSUE_CTRL_STATS_EN
    chk("stall_ten", stall_cycles, 10);
`else
    chk("stall_off", stall_cycles, 0);
`endif
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
